sparse_mem_model: RTL and testbench
===================================

Name: sparse_mem_model

Overview:
- Sparse, associative 64-bit memory model; direct downstream consumer of the traffic generator's wen/ren/addr/wdin bus.
- Returns rdout one cycle after ren.
- Stores up to DEPTH distinct addresses in a fully associative tag/data table, so a 64-bit address space needs no full-size array.
- Unwritten addresses read back a fixed default.

Parameters:
AW, 64, address width
DW, 64, data width
DEPTH, 16, number of table entries (power of two, >=2)
DEFAULT_DATA, 64'hDEAD_BEEF_DEAD_BEEF, rdout value on read miss (truncated to DW)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
wen  input  1  write strobe, one transaction per cycle high
ren  input  1  read strobe, one transaction per cycle high
addr  input  AW  transaction address, shared by read and write
wdin  input  DW  write data
rdout  output  DW  read data, valid when rvalid=1
rvalid  output  1  one-cycle pulse, cycle after an accepted ren
rhit  output  1  qualifies rdout: 1 = address found, 0 = DEFAULT_DATA returned
count  output  $clog2(DEPTH+1)  number of valid entries
full  output  1  count==DEPTH
overflow  output  1  sticky: a write to a new address was dropped because the table was full

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - On rst: all entry valid bits cleared.
  - Outputs on reset: rdout=0, rvalid=0, rhit=0, count=0, full=0, overflow=0.
  - Tag/data contents need not be cleared.
  - Reset mid-operation aborts any in-flight read; rvalid stays 0.
- Lookup: combinational compare of addr against all valid tags, giving a one-hot hit vector. At most one entry can match.
- Write (wen=1), registered on the clock edge:
  - Hit: overwrite that entry's data; count unchanged.
  - Miss, not full: allocate the lowest-index invalid entry; set tag=addr, data=wdin, valid=1; count+1.
  - Miss, full: default build drops the write and sets overflow=1 (sticky until rst). Behaviour changes with SPARSE_MEM_EVICT_EN.
- Read (ren=1), latency 1:
  - Next cycle: rvalid=1, rhit=hit, rdout = entry data on hit, DEFAULT_DATA on miss.
  - rvalid low in all other cycles.
  - rdout and rhit hold their last values when no read is in progress.
- Simultaneous wen and ren, same addr: read returns the pre-write contents (read-old); the write commits in the same edge.
  - Example: a first write to A plus a read of A in the same cycle gives rhit=0 and DEFAULT_DATA.
- Back-to-back reads every cycle are supported at full rate.
- count never exceeds DEPTH and never decrements except via rst or eviction replacement (see below).
- full is derived combinationally from count.
- Width: addr compared full AW bits; no aliasing.

Optional Feature:
- Macro: SPARSE_MEM_EVICT_EN.
- Defined:
  - A $clog2(DEPTH)-bit round-robin victim pointer, reset to 0, is added.
  - A write miss while full replaces the entry at the victim pointer (tag=addr, data=wdin), then increments the pointer modulo DEPTH.
  - count stays DEPTH; overflow is never set (tied 0).
  - A write hit does not move the pointer.
- Not defined: the pointer logic is absent, and full-table write misses are dropped and set overflow as above.

Test Plan:
- rst=1 then released; read addr 64'h1234 -> one cycle later rvalid=1, rhit=0, rdout=DEFAULT_DATA; count=0, full=0.
- Write addr=64'h10 data=64'hAA, next cycle read 64'h10 -> rvalid=1, rhit=1, rdout=64'hAA, count=1; rewrite 64'h10 with 64'hBB -> read gives 64'hBB, count still 1.
- DEPTH=4: write addrs 1,2,3,4 (data 11,22,33,44) -> full=1, count=4; write addr 5 data 55 without macro -> overflow=1, read 5 misses, reads 1..4 return 11..44. With SPARSE_MEM_EVICT_EN -> addr 1 is evicted (read 1 misses, read 5 = 55), overflow=0; a further new write evicts addr 2.
- Same-cycle wen+ren to new addr 64'h77 data 64'h99 -> rhit=0, rdout=DEFAULT_DATA; read next cycle -> rhit=1, rdout=64'h99.
- Random traffic matching upstream pattern (one write at counter=10, one read at counter=15, random 32-bit addr/data, 500 iterations), checked against a scoreboard associative array -> zero mismatches; overflow asserted only when distinct addresses exceed DEPTH.
- Assert rst while ren issued mid-stream -> rvalid stays 0, count=0, previously written addresses read back as misses.

Source files
------------

// File: rtl/sparse_mem_model.sv
// sparse_mem_model: sparse fully associative memory model with one-cycle read latency
// Build option: define SPARSE_MEM_EVICT_EN to replace entries round-robin on full-table write misses
// Ports: clk, rst (async active-high); wen/ren/addr/wdin request bus;
//        rdout/rvalid/rhit read response; count/full/overflow table occupancy status
module sparse_mem_model #(
  parameter int AW = 64,
  parameter int DW = 64,
  parameter int DEPTH = 16,
  parameter logic [63:0] DEFAULT_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wen,
  input  logic                       ren,
  input  logic [AW-1:0]              addr,
  input  logic [DW-1:0]              wdin,
  output logic [DW-1:0]              rdout,
  output logic                       rvalid,
  output logic                       rhit,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [DW-1:0] DEF = DW'(DEFAULT_DATA);
  logic [DEPTH-1:0] valid_q, valid_d, hit_vec;
  logic [AW-1:0] tag_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic [DW-1:0] rdout_q, rdout_d;
  logic rhit_q, rhit_d, rvalid_q;
  logic [IW-1:0] hit_idx, free_idx, wr_idx, victim;
  logic hit, has_free, alloc, miss_full, wr_en;
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) hit_vec[i] = valid_q[i] && (tag_q[i] == addr);
  end
  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    hit_idx = '0;
    free_idx = '0;
    has_free = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = i[IW-1:0];
      if (!valid_q[i]) begin
        free_idx = i[IW-1:0];
        has_free = 1'b1;
      end
    end
  end
  assign hit = |hit_vec;
  assign alloc = wen && !hit && has_free;
  assign miss_full = wen && !hit && !has_free;
`ifdef SPARSE_MEM_EVICT_EN
  logic [IW-1:0] victim_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) victim_q <= '0;
    else if (miss_full) victim_q <= victim_q + 1'b1;
  end
  assign victim = victim_q;
  assign wr_en = wen;
  assign overflow_d = 1'b0;
`else
  assign victim = '0;
  assign wr_en = wen && !miss_full;
  assign overflow_d = overflow_q || miss_full;
`endif
  assign wr_idx = hit ? hit_idx : has_free ? free_idx : victim;
  assign valid_d = alloc ? (valid_q | (DEPTH'(1) << free_idx)) : valid_q;
  assign count_d = count_q + CW'(alloc);
  // Read data is taken from pre-edge contents, giving read-old on a same-cycle write.
  assign rdout_d = ren ? (hit ? data_q[hit_idx] : DEF) : rdout_q;
  assign rhit_d = ren ? hit : rhit_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      rdout_q <= '0;
      rhit_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
      rdout_q <= rdout_d;
      rhit_q <= rhit_d;
      rvalid_q <= ren;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= addr;
      data_q[wr_idx] <= wdin;
    end
  end
  assign rdout = rdout_q;
  assign rhit = rhit_q;
  assign rvalid = rvalid_q;
  assign count = count_q;
  assign full = count_q == CW'(DEPTH);
  assign overflow = overflow_q;
endmodule

// File: tb/tb_sparse_mem_model.sv
// tb_sparse_mem_model: directed plus random checks of sparse_mem_model against a map/FIFO reference
module tb_sparse_mem_model;
  localparam int DEPTH = 4;
  localparam logic [63:0] DEF = 64'hDEAD_BEEF_DEAD_BEEF;
  logic clk = 1'b0, rst = 1'b1, wen = 1'b0, ren = 1'b0;
  logic [63:0] addr = '0, wdin = '0, rdout;
  logic rvalid, rhit, full, overflow;
  logic [2:0] count;
  logic [63:0] mem [logic [63:0]];
  logic [63:0] order [$];
  logic model_ov = 1'b0;
  logic [63:0] pool [6];
  int errors = 0, checks = 0;
  sparse_mem_model #(.AW(64), .DW(64), .DEPTH(DEPTH), .DEFAULT_DATA(DEF)) dut (
    .clk(clk), .rst(rst), .wen(wen), .ren(ren), .addr(addr), .wdin(wdin),
    .rdout(rdout), .rvalid(rvalid), .rhit(rhit), .count(count), .full(full), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_clear();
    mem.delete();
    order.delete();
    model_ov = 1'b0;
  endtask
  // Resident addresses are kept in insertion order; eviction replaces the oldest.
  task automatic model_write(input logic [63:0] a, input logic [63:0] d);
    if (mem.exists(a)) mem[a] = d;
    else if (order.size() < DEPTH) begin
      order.push_back(a);
      mem[a] = d;
    end else begin
`ifdef SPARSE_MEM_EVICT_EN
      mem.delete(order.pop_front());
      order.push_back(a);
      mem[a] = d;
`else
      model_ov = 1'b1;
`endif
    end
  endtask
  task automatic chk_status(input string tag);
    chk({tag, ".count"}, 64'(count), 64'(order.size()));
    chk({tag, ".full"}, 64'(full), 64'(order.size() == DEPTH));
    chk({tag, ".overflow"}, 64'(overflow), 64'(model_ov));
  endtask
  task automatic access(input string tag, input bit w, input bit r, input logic [63:0] a, input logic [63:0] d);
    logic eh;
    logic [63:0] ed;
    eh = mem.exists(a);
    ed = eh ? mem[a] : DEF;
    wen = w;
    ren = r;
    addr = a;
    wdin = d;
    tick();
    wen = 1'b0;
    ren = 1'b0;
    if (w) model_write(a, d);
    chk({tag, ".rvalid"}, 64'(rvalid), 64'(r));
    if (r) begin
      chk({tag, ".rhit"}, 64'(rhit), 64'(eh));
      chk({tag, ".rdout"}, rdout, ed);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
  endtask
  initial begin
    logic [63:0] held;
    do_reset();
    chk("reset.rdout", rdout, 64'h0);
    chk("reset.rvalid", 64'(rvalid), 64'h0);
    chk("reset.rhit", 64'(rhit), 64'h0);
    chk_status("reset");
    access("miss1234", 1'b0, 1'b1, 64'h1234, '0);
    chk("miss1234.rdout_const", rdout, DEF);
    chk_status("miss1234");
    access("wr10", 1'b1, 1'b0, 64'h10, 64'hAA);
    access("rd10", 1'b0, 1'b1, 64'h10, '0);
    chk("rd10.const", rdout, 64'hAA);
    chk_status("rd10");
    access("rewr10", 1'b1, 1'b0, 64'h10, 64'hBB);
    access("rd10b", 1'b0, 1'b1, 64'h10, '0);
    chk("rd10b.const", rdout, 64'hBB);
    chk_status("rd10b");
    held = rdout;
    tick();
    chk("idle.rvalid", 64'(rvalid), 64'h0);
    chk("idle.rdout_hold", rdout, held);
    do_reset();
    for (int i = 1; i <= 4; i++) access($sformatf("fill%0d", i), 1'b1, 1'b0, 64'(i), 64'(i * 'h11));
    chk_status("filled");
    chk("filled.full", 64'(full), 64'h1);
    access("wr5", 1'b1, 1'b0, 64'h5, 64'h55);
    chk_status("wr5");
    for (int i = 1; i <= 5; i++) access($sformatf("rdfull%0d", i), 1'b0, 1'b1, 64'(i), '0);
    access("wr6", 1'b1, 1'b0, 64'h6, 64'h66);
    for (int i = 1; i <= 6; i++) access($sformatf("rdfull6_%0d", i), 1'b0, 1'b1, 64'(i), '0);
    chk_status("wr6");
    do_reset();
    access("wrrd77", 1'b1, 1'b1, 64'h77, 64'h99);
    chk("wrrd77.rhit_const", 64'(rhit), 64'h0);
    access("rd77", 1'b0, 1'b1, 64'h77, '0);
    chk("rd77.const", rdout, 64'h99);
    do_reset();
    for (int i = 0; i < 6; i++) pool[i] = 64'($urandom);
    for (int it = 0; it < 500; it++) begin
      int op;
      op = $urandom_range(0, 2);
      access($sformatf("rand%0d", it), op != 1, op != 0, pool[$urandom_range(0, 5)], 64'($urandom));
      chk_status($sformatf("rand%0d", it));
    end
    do_reset();
    access("pre_a", 1'b1, 1'b0, 64'hA0, 64'h1);
    access("pre_b", 1'b1, 1'b0, 64'hB0, 64'h2);
    ren = 1'b1;
    addr = 64'hA0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    ren = 1'b0;
    chk("midrst.rvalid", 64'(rvalid), 64'h0);
    chk("midrst.rdout", rdout, 64'h0);
    rst = 1'b0;
    model_clear();
    chk_status("midrst");
    access("post_a", 1'b0, 1'b1, 64'hA0, '0);
    chk("post_a.rhit_const", 64'(rhit), 64'h0);
    access("post_b", 1'b0, 1'b1, 64'hB0, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
